// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl shared definitions: register window, offsets, FSM states.
// Optional 2-flop input synchronizers are enabled by defining IRQ_SYNC_EN.
package irq_ctrl_pkg;

    localparam logic [31:0] IRQ_MASK_DFLT = 32'hffff0040;

    localparam logic [3:0] IRQ_PEND  = 4'h0;
    localparam logic [3:0] IRQ_ENAB  = 4'h4;
    localparam logic [3:0] IRQ_CLAIM = 4'h8;
    localparam logic [3:0] IRQ_CMPL  = 4'hC;

    localparam logic [4:0] IRQ_TIMER_ID = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    function automatic logic win_hit(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        return addr[31:4] == base[31:4];
    endfunction

endpackage

// File: rtl/irq_gateway.sv
// Per-source gateway: optional sync (IRQ_SYNC_EN), rise detect, pending flop.
// A new edge beats a simultaneous clear so no interrupt is ever lost.
module irq_gateway (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic clr,
    output logic pend
);

    logic src_s;
    logic src_d;
    logic rise;

`ifdef IRQ_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], src};
        end
    end

    assign src_s = sync_q[1];
`else
    assign src_s = src;
`endif

    assign rise = src_s & ~src_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            src_d <= 1'b0;
            pend  <= 1'b0;
        end else begin
            src_d <= src_s;
            if (rise) begin
                pend <= 1'b1;
            end else if (clr) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: priority encoder, claim/complete FSM,
// register decode and tri-state read mux. IRQ_SYNC_EN adds input synchronizers.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int          N_SRC    = 4,
    parameter logic [31:0] IRQ_MASK = IRQ_MASK_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_we,
    input  logic [31:0]      mem_addr,
    inout  wire  [31:0]      mem_data,
    input  logic [N_SRC-1:0] src_int,
    output logic             irq,
    output logic [4:0]       irq_id
);

    irq_state_e       state;
    irq_state_e       state_n;
    logic             irq_n;
    logic [4:0]       id_n;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] enab;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] act;
    logic             any_act;
    logic [4:0]       best_id;
    logic             hit;
    logic [3:0]       off;
    logic             wr_enab;
    logic             wr_claim;
    logic             wr_cmpl;
    logic             cmpl_ok;
    logic [31:0]      rd_data;

    for (genvar g = 0; g < N_SRC; g++) begin : g_gw
        irq_gateway u_gw (
            .clk  (clk),
            .rst  (rst),
            .src  (src_int[g]),
            .clr  (clr[g]),
            .pend (pend[g])
        );
        assign clr[g] = cmpl_ok && (irq_id == 5'(g));
    end

    assign hit      = win_hit(mem_addr, IRQ_MASK);
    assign off      = mem_addr[3:0];
    assign wr_enab  = mem_we && hit && (off == IRQ_ENAB);
    assign wr_claim = mem_we && hit && (off == IRQ_CLAIM);
    assign wr_cmpl  = mem_we && hit && (off == IRQ_CMPL);
    assign cmpl_ok  = wr_cmpl && (state == ST_SERVICE)
                   && (mem_data[4:0] == irq_id);

    assign act     = pend & enab;
    assign any_act = |act;

    // Walk downward so the lowest index is assigned last and wins.
    always_comb begin
        best_id = IRQ_TIMER_ID;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (act[i]) begin
                best_id = 5'(i);
            end
        end
    end

    always_comb begin
        state_n = state;
        irq_n   = irq;
        id_n    = irq_id;
        unique case (state)
            ST_IDLE: begin
                if (any_act) begin
                    state_n = ST_ASSERT;
                    irq_n   = 1'b1;
                    id_n    = best_id;
                end else begin
                    irq_n = 1'b0;
                    id_n  = '0;
                end
            end
            ST_ASSERT: begin
                if (wr_claim) begin
                    state_n = ST_SERVICE;
                    irq_n   = 1'b0;
                end else if (!any_act) begin
                    state_n = ST_IDLE;
                    irq_n   = 1'b0;
                    id_n    = '0;
                end else begin
                    irq_n = 1'b1;
                    id_n  = best_id;
                end
            end
            ST_SERVICE: begin
                irq_n = 1'b0;
                if (cmpl_ok) begin
                    state_n = ST_IDLE;
                    id_n    = '0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                irq_n   = 1'b0;
                id_n    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_IDLE;
            irq    <= 1'b0;
            irq_id <= '0;
            enab   <= '0;
        end else begin
            state  <= state_n;
            irq    <= irq_n;
            irq_id <= id_n;
            if (wr_enab) begin
                enab <= mem_data[N_SRC-1:0];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        unique case (1'b1)
            off == IRQ_PEND:  rd_data[N_SRC-1:0] = pend;
            off == IRQ_ENAB:  rd_data[N_SRC-1:0] = enab;
            off == IRQ_CLAIM: rd_data = {any_act, 26'b0, best_id};
            default:          rd_data = '0;
        endcase
    end

    assign mem_data = (hit && !mem_we) ? rd_data : 'z;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus random traffic
// compared against a behavioural model of pending/enable/claim rules.
module tb_irq_ctrl;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'hffff0040;
`ifdef IRQ_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          mem_we   = 1'b0;
    logic [31:0]   mem_addr = '0;
    logic [31:0]   wdata    = '0;
    logic [N-1:0]  src_int  = '0;
    wire  [31:0]   mem_data;
    logic          irq;
    logic [4:0]    irq_id;

    assign mem_data = mem_we ? wdata : 'z;

    for (genvar g = 0; g < 32; g++) begin : g_pu
        pullup (mem_data[g]);
    end

    irq_ctrl #(.N_SRC(N), .IRQ_MASK(BASE)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .src_int  (src_int),
        .irq      (irq),
        .irq_id   (irq_id)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference model: 0 idle, 1 requesting, 2 in service
    int           m_mode;
    logic [N-1:0] m_pend;
    logic [N-1:0] m_enab;
    logic [N-1:0] m_prev;
    logic [N-1:0] m_s1;
    logic [N-1:0] m_s2;
    logic         m_irq;
    logic [4:0]   m_id;

    function automatic int m_best();
        for (int i = 0; i < N; i++) begin
            if (m_pend[i] && m_enab[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int b;
        if (a[31:4] != BASE[31:4]) return 32'hffff_ffff;
        b = m_best();
        case (a[3:0])
            4'h0: return 32'(m_pend);
            4'h4: return 32'(m_enab);
            4'h8: return (b < 0) ? 32'h0 : (32'h8000_0000 | 32'(b));
            default: return 32'h0;
        endcase
    endfunction

    task automatic step(input logic r, input logic [N-1:0] s,
                        input logic we, input logic [31:0] a,
                        input logic [31:0] d);
        logic [N-1:0] seen;
        logic [N-1:0] rise;
        logic [N-1:0] clr;
        logic         in_win;
        int           b;
        rst      = r;
        src_int  = s;
        mem_we   = we;
        mem_addr = a;
        wdata    = d;
        #1;
        check("irq", 32'(irq), 32'(m_irq));
        check("irq_id", 32'(irq_id), 32'(m_id));
        if (!we) check("rdata", mem_data, m_read(a));
        @(posedge clk);
        if (!r) begin
            m_mode = 0;
            m_pend = '0;
            m_enab = '0;
            m_prev = '0;
            m_s1   = '0;
            m_s2   = '0;
            m_irq  = 1'b0;
            m_id   = '0;
        end else begin
`ifdef IRQ_SYNC_EN
            seen = m_s2;
            m_s2 = m_s1;
            m_s1 = s;
`else
            seen = s;
`endif
            rise   = seen & ~m_prev;
            m_prev = seen;
            clr    = '0;
            b      = m_best();
            in_win = (a[31:4] == BASE[31:4]);
            case (m_mode)
                0: if (b >= 0) begin
                    m_mode = 1;
                    m_irq  = 1'b1;
                    m_id   = 5'(b);
                end
                1: if (we && in_win && a[3:0] == 4'h8) begin
                    m_mode = 2;
                    m_irq  = 1'b0;
                end else if (b < 0) begin
                    m_mode = 0;
                    m_irq  = 1'b0;
                    m_id   = '0;
                end else begin
                    m_id = 5'(b);
                end
                default: if (we && in_win && a[3:0] == 4'hC
                             && d[4:0] == m_id) begin
                    clr[m_id] = 1'b1;
                    m_mode    = 0;
                    m_id      = '0;
                end
            endcase
            m_pend = (m_pend & ~clr) | rise;
            if (we && in_win && a[3:0] == 4'h4) m_enab = d[N-1:0];
        end
        @(negedge clk);
    endtask

    task automatic rd(input logic [N-1:0] s, input logic [3:0] o);
        step(1'b1, s, 1'b0, BASE + 32'(o), 32'h0);
    endtask

    task automatic wr(input logic [N-1:0] s, input logic [3:0] o,
                      input logic [31:0] d);
        step(1'b1, s, 1'b1, BASE + 32'(o), d);
    endtask

    initial begin
        logic [N-1:0] s;
        logic [31:0]  a;
        logic [31:0]  d;
        logic         we;
        logic         r;
        int           op;
        m_mode = 0; m_pend = '0; m_enab = '0; m_prev = '0;
        m_s1 = '0; m_s2 = '0; m_irq = 1'b0; m_id = '0;
        @(negedge clk);
        step(1'b0, '0, 1'b0, BASE, 32'h0);
        step(1'b0, '0, 1'b0, BASE, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_id", 32'(irq_id), 32'h0);

        // timer alone: latency, claim value, claim/complete
        wr(4'h0, 4'h4, 32'h1);
        rd(4'h1, 4'h8);
        for (int k = 1; k < LAT; k++) begin
            check("t1_wait", 32'(irq), 32'h0);
            rd(4'h1, 4'h8);
        end
        check("t1_irq", 32'(irq), 32'h1);
        check("t1_claim", mem_data, 32'h8000_0000);
        wr(4'h0, 4'h8, 32'h0);
        check("t1_unclaim", 32'(irq), 32'h0);
        wr(4'h0, 4'hC, 32'h0);
        rd(4'h0, 4'h0);
        check("t1_pend", mem_data, 32'h0);
        check("t1_idle", 32'(irq), 32'h0);

        // two sources together: lower index first, then the other
        wr(4'h0, 4'h4, 32'hF);
        rd(4'h6, 4'h8);
        repeat (LAT) rd(4'h6, 4'h8);
        check("t2_id1", 32'(irq_id), 32'h1);
        wr(4'h0, 4'h8, 32'h0);
        wr(4'h0, 4'hC, 32'h1);
        rd(4'h0, 4'h8);
        check("t2_irq", 32'(irq), 32'h1);
        check("t2_id2", 32'(irq_id), 32'h2);
        wr(4'h0, 4'h8, 32'h0);
        wr(4'h0, 4'hC, 32'h2);
        rd(4'h0, 4'h0);

        // disabled source stays latched, enable releases it
        wr(4'h0, 4'h4, 32'h0);
        rd(4'h8, 4'h0);
        repeat (LAT) rd(4'h0, 4'h0);
        check("t3_pend", mem_data, 32'h8);
        check("t3_noirq", 32'(irq), 32'h0);
        wr(4'h0, 4'h4, 32'h8);
        rd(4'h0, 4'h8);
        check("t3_irq", 32'(irq), 32'h1);
        check("t3_id", 32'(irq_id), 32'h3);
        wr(4'h0, 4'h8, 32'h0);
        wr(4'h0, 4'hC, 32'h3);
        rd(4'h0, 4'h0);

        // wrong-id complete ignored; new edge beats complete
        wr(4'h0, 4'h4, 32'hF);
        rd(4'h2, 4'h0);
        repeat (LAT) rd(4'h0, 4'h0);
        wr(4'h0, 4'h8, 32'h0);
        wr(4'h0, 4'hC, 32'h2);
        check("t4_ign_irq", 32'(irq), 32'h0);
        check("t4_ign_id", 32'(irq_id), 32'h1);
        rd(4'h0, 4'h0);
        repeat (LAT - 2) rd(4'h2, 4'h0);
        wr(4'h2, 4'hC, 32'h1);
        rd(4'h2, 4'h0);
        check("t4_keep", mem_data, 32'h2);

        // reset in service
        wr(4'h0, 4'h8, 32'h0);
        step(1'b0, '0, 1'b0, BASE, 32'h0);
        check("t5_irq", 32'(irq), 32'h0);
        check("t5_id", 32'(irq_id), 32'h0);
        rd(4'h0, 4'h0);
        check("t5_pend", mem_data, 32'h0);
        rd(4'h0, 4'h4);
        check("t5_enab", mem_data, 32'h0);
        step(1'b1, '0, 1'b0, 32'h0000_1000, 32'h0);
        check("t5_bz", mem_data, 32'hffff_ffff);
        rd(4'h0, 4'h2);
        check("t5_hole", mem_data, 32'h0);

        // random traffic against the model
        for (int i = 0; i < 800; i++) begin
            r  = ($urandom_range(0, 149) != 0);
            s  = src_int;
            if ($urandom_range(0, 2) == 0) s = s ^ N'($urandom);
            op = $urandom_range(0, 9);
            we = 1'b1;
            d  = $urandom;
            a  = BASE;
            if (op <= 3) begin
                we = 1'b0;
                a  = ($urandom_range(0, 7) == 0) ? $urandom
                                                 : BASE + $urandom_range(0, 15);
            end else if (op == 4) begin
                a = BASE + 32'h4;
            end else if (op <= 6) begin
                a = BASE + 32'h8;
            end else if (op <= 8) begin
                a = BASE + 32'hC;
                if ($urandom_range(0, 3) != 0) d = 32'(m_id);
                else d = 32'($urandom_range(0, N - 1));
            end else begin
                a = ($urandom_range(0, 1) == 0) ? $urandom
                                                : BASE + $urandom_range(0, 15);
            end
            step(r, s, we, a, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
